wb_arbiter: RTL
===============

// Module: wb_arbiter
// PURPOSE
// Writeback arbiter and destination scoreboard between execute and reg_file.
// Merges the in-order pipeline writeback (no backpressure) with results from the
// long-latency unit (mul/div, valid/ready) onto reg_file's single write port
// (reg_we/rd/wd). Tracks in-flight long-latency destinations so decode can stall on RAW.
// PARAMETERS
// XLEN        32  data width of wd / result buses
// FIFO_DEPTH  2   long-latency result buffer entries (>=1)
// STARVE_MAX  4   cycles a buffered result may wait before pipe_stall is raised
// PORTS
// clk            in   1     clock, all state on rising edge
// reset          in   1     asynchronous, active-low reset (0 = reset)
// pipe_valid     in   1     pipeline writeback valid this cycle
// pipe_rd        in   5     pipeline destination register
// pipe_wd        in   XLEN  pipeline writeback data
// lu_valid       in   1     long-latency result valid
// lu_ready       out  1     arbiter can accept a long-latency result
// lu_rd          in   5     long-latency destination register
// lu_wd          in   XLEN  long-latency result data
// issue_valid    in   1     long-latency op issued this cycle
// issue_rd       in   5     destination of the issued op
// rs1 / rs2      in   5     decode source registers to check
// rs1_busy/rs2_busy out 1   source has an outstanding long-latency write
// issue_conflict out  1     issue_valid to an rd that is already pending
// pipe_stall     out  1     request upstream to insert a bubble next cycle
// reg_we         out  1     to reg_file write enable (registered)
// rd             out  5     to reg_file destination (registered)
// wd             out  XLEN  to reg_file write data (registered)
// BEHAVIOUR
// - Reset (reset=0, async): reg_we=0, rd=0, wd=0, FIFO empty, pending[31:0]=0,
//   starve counter=0, pipe_stall=0; lu_ready forced 0 while reset is low.
// - lu handshake: transfer on lu_valid&&lu_ready at clk edge; lu_ready=(FIFO not
//   full), combinational from registered count, never from lu_valid. Data pushed FIFO.
// - Arbitration each cycle: pipe_valid wins; else FIFO head is popped. Winner is
//   registered: reg_we/rd/wd valid 1 cycle after selection; idle cycle -> reg_we=0.
// - rd==0 writes (either source) are consumed but produce reg_we=0; lu entry still pops.
// - FIFO empty and lu handshake same cycle: no bypass; result waits >=1 cycle in FIFO.
// - Push and pop same cycle when full: allowed only if pop occurs; lu_ready reflects
//   pre-edge count, so full FIFO => lu_ready=0 regardless of pending pop.
// - Starvation: counter increments each cycle FIFO is non-empty and pipe_valid=1,
//   clears on any pop or when empty. pipe_stall=1 (registered) when counter>=STARVE_MAX;
//   pipe_valid is still honoured if asserted while pipe_stall=1 (no data loss).
// - Scoreboard: pending[issue_rd] set on issue_valid (issue_rd!=0). Cleared on the
//   edge where reg_file captures it: reg_we=1 with source=lu and rd matching.
//   Set and clear of same index same edge: set wins. pending[0] always 0.
// - rsN_busy = pending[rsN], combinational; issue_conflict = issue_valid &&
//   pending[issue_rd]; conflicting issue leaves the bit set (no counting).
// - Reset mid-operation: FIFO contents, pending bits and output write dropped at once.
// TESTING
// - Reset low 3 cycles then high -> reg_we=0, rd=0, wd=0, lu_ready=1, rs1_busy=0.
// - pipe_valid, rd=5, wd=0xDEADBEEF for 1 cycle -> next cycle reg_we=1, rd=5, wd=0xDEADBEEF.
// - issue rd=7; lu result rd=7 wd=0x12 while pipe idle -> rs1=7 busy until cycle
//   after reg_we=1/rd=7, then rs1_busy=0.
// - pipe_valid held high, 2 lu results pushed -> lu_ready=0 when full; pipe_stall=1
//   after 4 cycles; first pipe bubble pops rd/wd of first lu result in order.
// - pipe rd=0 wd=0xFF and lu rd=0 -> reg_we stays 0, lu entry popped, FIFO empty.
// - issue rd=3 twice -> second cycle issue_conflict=1; reset mid-FIFO -> all pending cleared.

Source files
------------

// File: rtl/wb_arbiter.sv
// Writeback arbiter: merges the pipeline writeback with buffered long-latency results
// onto the single reg_file write port, and tracks pending long-latency destinations.
module wb_arbiter #(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned FIFO_DEPTH = 2,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            pipe_valid,
  input  logic [4:0]      pipe_rd,
  input  logic [XLEN-1:0] pipe_wd,
  input  logic            lu_valid,
  output logic            lu_ready,
  input  logic [4:0]      lu_rd,
  input  logic [XLEN-1:0] lu_wd,
  input  logic            issue_valid,
  input  logic [4:0]      issue_rd,
  input  logic [4:0]      rs1,
  input  logic [4:0]      rs2,
  output logic            rs1_busy,
  output logic            rs2_busy,
  output logic            issue_conflict,
  output logic            pipe_stall,
  output logic            reg_we,
  output logic [4:0]      rd,
  output logic [XLEN-1:0] wd
);

  localparam int unsigned PtrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CntW = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned StW  = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;

  logic [4:0]      fifo_rd [FIFO_DEPTH];
  logic [XLEN-1:0] fifo_wd [FIFO_DEPTH];
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] count_q, count_d;
  logic [StW-1:0]  starve_q, starve_d;
  logic            stall_q, stall_d;
  logic [31:0]     pending_q, pending_d;
  logic            reg_we_q, reg_we_d, src_lu_q, src_lu_d;
  logic [4:0]      rd_q, rd_d;
  logic [XLEN-1:0] wd_q, wd_d;
  logic            push, pop, empty;

  assign empty    = (count_q == '0);
  // Readiness depends only on the registered count, so a full FIFO never accepts a
  // result even when it is being popped on the same edge.
  assign lu_ready = reset && (count_q != CntW'(FIFO_DEPTH));
  assign push     = lu_valid && lu_ready;
  assign pop      = !pipe_valid && !empty;

  assign rs1_busy       = pending_q[rs1];
  assign rs2_busy       = pending_q[rs2];
  assign issue_conflict = issue_valid && pending_q[issue_rd];
  assign pipe_stall     = stall_q;
  assign reg_we         = reg_we_q;
  assign rd             = rd_q;
  assign wd             = wd_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      wr_ptr_d = (wr_ptr_q == PtrW'(FIFO_DEPTH - 1)) ? '0 : wr_ptr_q + PtrW'(1);
    end
    if (pop) begin
      rd_ptr_d = (rd_ptr_q == PtrW'(FIFO_DEPTH - 1)) ? '0 : rd_ptr_q + PtrW'(1);
    end
    if (push && !pop) begin
      count_d = count_q + CntW'(1);
    end else if (pop && !push) begin
      count_d = count_q - CntW'(1);
    end
  end

  always_comb begin
    reg_we_d = 1'b0;
    src_lu_d = 1'b0;
    rd_d     = rd_q;
    wd_d     = wd_q;
    if (pipe_valid) begin
      reg_we_d = (pipe_rd != 5'd0);
      rd_d     = pipe_rd;
      wd_d     = pipe_wd;
    end else if (pop) begin
      reg_we_d = (fifo_rd[rd_ptr_q] != 5'd0);
      src_lu_d = 1'b1;
      rd_d     = fifo_rd[rd_ptr_q];
      wd_d     = fifo_wd[rd_ptr_q];
    end
  end

  always_comb begin
    starve_d = starve_q;
    if (pop || empty) begin
      starve_d = '0;
    end else if (pipe_valid && (starve_q < StW'(STARVE_MAX))) begin
      starve_d = starve_q + StW'(1);
    end
    stall_d = (starve_d >= StW'(STARVE_MAX));
  end

  // Clear happens on the edge reg_file captures the lu write; a same-edge issue wins.
  always_comb begin
    pending_d = pending_q;
    if (reg_we_q && src_lu_q) begin
      pending_d[rd_q] = 1'b0;
    end
    if (issue_valid && (issue_rd != 5'd0)) begin
      pending_d[issue_rd] = 1'b1;
    end
    pending_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      starve_q  <= '0;
      stall_q   <= 1'b0;
      pending_q <= '0;
      reg_we_q  <= 1'b0;
      src_lu_q  <= 1'b0;
      rd_q      <= '0;
      wd_q      <= '0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      starve_q  <= starve_d;
      stall_q   <= stall_d;
      pending_q <= pending_d;
      reg_we_q  <= reg_we_d;
      src_lu_q  <= src_lu_d;
      rd_q      <= rd_d;
      wd_q      <= wd_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_rd[wr_ptr_q] <= lu_rd;
      fifo_wd[wr_ptr_q] <= lu_wd;
    end
  end

endmodule
